// File: rtl/img_filter_pipe.sv
// ============================================================================
// img_filter_pipe
// ----------------------------------------------------------------------------
// Two-stage pixel filter between the frame-buffer read mux and the VGA RGB
// outputs. Inside a configurable on-screen window it applies bypass, mosaic,
// grayscale, invert or threshold. Pixels outside the window pass through
// unchanged. The filter mode and the threshold level are latched only at frame
// start (x_pixel==0 && y_pixel==0). Every output is registered, and the latency
// is exactly 2 cycles.
//
// Optional feature macro: IMG_FILTER_BORDER_EN
//   When this macro is defined, pixels on the outermost rows and columns of
//   the window are forced to solid white in every mode.
//
// Ports:
//   clk          pixel clock, one pixel per cycle
//   reset        asynchronous active-low reset
//   filter_sel   requested mode (0 bypass, 1 mosaic, 2 gray, 3 invert,
//                4 threshold, 5-7 bypass)
//   thresh       threshold level for mode 4, latched together with filter_sel
//   DE           display enable
//   x_pixel      screen x coordinate
//   y_pixel      screen y coordinate
//   r_in         input red channel
//   g_in         input green channel
//   b_in         input blue channel
//   DE_out       DE delayed by 2 cycles
//   x_out        x_pixel delayed by 2 cycles
//   y_out        y_pixel delayed by 2 cycles
//   r_out        filtered red channel
//   g_out        filtered green channel
//   b_out        filtered blue channel
//   mode_active  mode currently applied
// ============================================================================
module img_filter_pipe #(
    parameter int COLOR_W     = 4,
    parameter int IMG_WIDTH   = 160,
    parameter int IMG_HEIGHT  = 120,
    parameter int WIN_X0      = 320,
    parameter int WIN_Y0      = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int BLOCK_SHIFT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         filter_sel,
    input  logic [COLOR_W-1:0] thresh,
    input  logic               DE,
    input  logic [9:0]         x_pixel,
    input  logic [9:0]         y_pixel,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic               DE_out,
    output logic [9:0]         x_out,
    output logic [9:0]         y_out,
    output logic [COLOR_W-1:0] r_out,
    output logic [COLOR_W-1:0] g_out,
    output logic [COLOR_W-1:0] b_out,
    output logic [2:0]         mode_active
);

    localparam int LX_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int LY_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int BX_W  = LX_W - BLOCK_SHIFT;
    // Round up so that a partial last block still has its own buffer entry.
    localparam int NBLK  = (IMG_WIDTH + (1 << BLOCK_SHIFT) - 1) >> BLOCK_SHIFT;
    localparam int PIX_W = 3 * COLOR_W;

    localparam logic [9:0] X_LO = 10'(WIN_X0);
    localparam logic [9:0] X_HI = 10'(WIN_X0 + (IMG_WIDTH << SCALE_SHIFT) - 1);
    localparam logic [9:0] Y_LO = 10'(WIN_Y0);
    localparam logic [9:0] Y_HI = 10'(WIN_Y0 + (IMG_HEIGHT << SCALE_SHIFT) - 1);
    localparam logic [9:0]      SUB_MASK = 10'((1 << SCALE_SHIFT) - 1);
    localparam logic [LX_W-1:0] LX_BMASK = LX_W'((1 << BLOCK_SHIFT) - 1);
    localparam logic [LY_W-1:0] LY_BMASK = LY_W'((1 << BLOCK_SHIFT) - 1);

    localparam logic [2:0] MODE_MOSAIC = 3'd1;
    localparam logic [2:0] MODE_GRAY   = 3'd2;
    localparam logic [2:0] MODE_INVERT = 3'd3;
    localparam logic [2:0] MODE_THRESH = 3'd4;

    // Stage 1 registers
    logic              s1_win_q,  s1_win_d;
    logic [LX_W-1:0]   s1_lx_q,   s1_lx_d;
    logic [LY_W-1:0]   s1_ly_q,   s1_ly_d;
    logic              s1_sub0_q, s1_sub0_d;   // first screen pixel of a local pixel
    logic [PIX_W-1:0]  s1_pix_q,  s1_pix_d;
    logic              s1_de_q,   s1_de_d;
    logic [9:0]        s1_x_q,    s1_x_d;
    logic [9:0]        s1_y_q,    s1_y_d;
`ifdef IMG_FILTER_BORDER_EN
    logic              s1_edge_q, s1_edge_d;
`endif

    // Frame-synchronous mode state and the mosaic hold register
    logic [2:0]         mode_q,   mode_d;
    logic [COLOR_W-1:0] thresh_q, thresh_d;
    logic [PIX_W-1:0]   hold_q,   hold_d;

    // Stage 2 output registers
    logic [PIX_W-1:0]  out_pix_q, out_pix_d;
    logic              de_out_q,  de_out_d;
    logic [9:0]        x_out_q,   x_out_d;
    logic [9:0]        y_out_q,   y_out_d;

    // Mosaic block buffer
    logic [PIX_W-1:0]  buf_mem [0:NBLK-1];
    logic              buf_we_s;

    logic [9:0]         dx_s, dy_s;
    logic               in_win_s;
    logic [COLOR_W-1:0] r1_s, g1_s, b1_s;
    logic [COLOR_W+1:0] gray_sum_s;
    logic [COLOR_W-1:0] gray_s;
    logic [BX_W-1:0]    bx_s;
    logic               cap_row_s, cap_pix_s;
    logic [PIX_W-1:0]   filt_s;

    // Stage 1: window decode, local coordinates and mode latch at frame start
    always_comb begin
        dx_s      = x_pixel - X_LO;
        dy_s      = y_pixel - Y_LO;
        in_win_s  = DE && (x_pixel >= X_LO) && (x_pixel <= X_HI)
                       && (y_pixel >= Y_LO) && (y_pixel <= Y_HI);
        s1_win_d  = in_win_s;
        s1_lx_d   = LX_W'(dx_s >> SCALE_SHIFT);
        s1_ly_d   = LY_W'(dy_s >> SCALE_SHIFT);
        s1_sub0_d = ((dx_s & SUB_MASK) == 10'd0);
        s1_pix_d  = {r_in, g_in, b_in};
        s1_de_d   = DE;
        s1_x_d    = x_pixel;
        s1_y_d    = y_pixel;
`ifdef IMG_FILTER_BORDER_EN
        s1_edge_d = in_win_s && ((x_pixel == X_LO) || (x_pixel == X_HI) ||
                                 (y_pixel == Y_LO) || (y_pixel == Y_HI));
`endif
        if ((x_pixel == 10'd0) && (y_pixel == 10'd0)) begin
            mode_d   = filter_sel;
            thresh_d = thresh;
        end else begin
            mode_d   = mode_q;
            thresh_d = thresh_q;
        end
    end

    // Stage 2: filter arithmetic, mosaic capture/replay and output selection
    always_comb begin
        {r1_s, g1_s, b1_s} = s1_pix_q;
        // r + 2g + b fits in COLOR_W+2 bits, so the sum cannot overflow.
        gray_sum_s = {2'b00, r1_s} + {1'b0, g1_s, 1'b0} + {2'b00, b1_s};
        gray_s     = gray_sum_s[COLOR_W+1:2];
        bx_s       = s1_lx_q[LX_W-1:BLOCK_SHIFT];
        cap_row_s  = ((s1_ly_q & LY_BMASK) == {LY_W{1'b0}});
        cap_pix_s  = cap_row_s && ((s1_lx_q & LX_BMASK) == {LX_W{1'b0}}) && s1_sub0_q;
        // Captures track the window in every mode, so the buffer is always current.
        buf_we_s   = s1_win_q && cap_pix_s;
        if (buf_we_s) begin
            hold_d = s1_pix_q;
        end else begin
            hold_d = hold_q;
        end

        case (mode_q)
            MODE_MOSAIC: begin
                if (cap_pix_s) begin
                    filt_s = s1_pix_q;
                end else if (cap_row_s) begin
                    filt_s = hold_q;
                end else begin
                    filt_s = buf_mem[bx_s];
                end
            end
            MODE_GRAY:   filt_s = {gray_s, gray_s, gray_s};
            MODE_INVERT: filt_s = ~s1_pix_q;
            MODE_THRESH: filt_s = (gray_s >= thresh_q) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
            default:     filt_s = s1_pix_q;
        endcase

        if (s1_win_q) begin
            out_pix_d = filt_s;
        end else begin
            out_pix_d = s1_pix_q;
        end
`ifdef IMG_FILTER_BORDER_EN
        if (s1_edge_q) begin
            out_pix_d = {PIX_W{1'b1}};
        end else begin
            out_pix_d = out_pix_d;
        end
`endif
        de_out_d = s1_de_q;
        x_out_d  = s1_x_q;
        y_out_d  = s1_y_q;
    end

    // Pipeline, mode and hold registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_win_q  <= 1'b0;
            s1_lx_q   <= {LX_W{1'b0}};
            s1_ly_q   <= {LY_W{1'b0}};
            s1_sub0_q <= 1'b0;
            s1_pix_q  <= {PIX_W{1'b0}};
            s1_de_q   <= 1'b0;
            s1_x_q    <= 10'd0;
            s1_y_q    <= 10'd0;
`ifdef IMG_FILTER_BORDER_EN
            s1_edge_q <= 1'b0;
`endif
            mode_q    <= 3'd0;
            thresh_q  <= {COLOR_W{1'b0}};
            hold_q    <= {PIX_W{1'b0}};
            out_pix_q <= {PIX_W{1'b0}};
            de_out_q  <= 1'b0;
            x_out_q   <= 10'd0;
            y_out_q   <= 10'd0;
        end else begin
            s1_win_q  <= s1_win_d;
            s1_lx_q   <= s1_lx_d;
            s1_ly_q   <= s1_ly_d;
            s1_sub0_q <= s1_sub0_d;
            s1_pix_q  <= s1_pix_d;
            s1_de_q   <= s1_de_d;
            s1_x_q    <= s1_x_d;
            s1_y_q    <= s1_y_d;
`ifdef IMG_FILTER_BORDER_EN
            s1_edge_q <= s1_edge_d;
`endif
            mode_q    <= mode_d;
            thresh_q  <= thresh_d;
            hold_q    <= hold_d;
            out_pix_q <= out_pix_d;
            de_out_q  <= de_out_d;
            x_out_q   <= x_out_d;
            y_out_q   <= y_out_d;
        end
    end

    // Block buffer write; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_mem[bx_s] <= s1_pix_q;
        end
    end

    assign {r_out, g_out, b_out} = out_pix_q;
    assign DE_out      = de_out_q;
    assign x_out       = x_out_q;
    assign y_out       = y_out_q;
    assign mode_active = mode_q;

endmodule
